// File: rtl/uart_save_capture.sv
// Captures the machine's 8N1 serial output into a block-RAM byte buffer and serves it to the HPS upload path.
// Optional: define UK101_SAVE_FILTER_EN to discard NUL (0x00) and rubout (0x7F) bytes before storage.
module uart_save_capture #(
  parameter int CLK_HZ = 48000000,
  parameter int ADDR_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              capture_clear,
  input  logic              baud_rate,
  input  logic              txd,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [15:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W:0]   capture_len,
  output logic              overflow,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [17:0] BP_FAST = 18'(CLK_HZ / 9600);
  localparam logic [17:0] BP_SLOW = 18'(CLK_HZ / 300);
  localparam int          DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [17:0] bit_period(input logic slow);
    return slow ? BP_SLOW : BP_FAST;
  endfunction

  function automatic logic keep_byte(input logic [7:0] b);
`ifdef UK101_SAVE_FILTER_EN
    return (b != 8'h00) && (b != 8'h7F);
`else
    return (b == b);
`endif
  endfunction

  logic        txd_p0, txd_p1, txd_p2;
  logic        rx_fall, rx_bit;
  state_t      state;
  logic [17:0] cnt;
  logic [2:0]  idx;
  logic        baud_lat;
  logic [7:0]  shreg;
  logic        rx_vld_p0;
  logic        cnt_zero;
  logic        store_ok;
  logic        wr_en;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  ram_q_p0;
  logic        rd_vld_p0, rd_ok_p0;
  logic        in_range;

  // Stage: txd synchroniser plus one extra flop for falling-edge detect
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      txd_p0 <= 1'b1;
      txd_p1 <= 1'b1;
      txd_p2 <= 1'b1;
    end else begin
      txd_p0 <= txd;
      txd_p1 <= txd_p0;
      txd_p2 <= txd_p1;
    end
  end

  assign rx_bit   = txd_p1;
  assign rx_fall  = txd_p2 & ~txd_p1;
  assign cnt_zero = (cnt == 18'd0);
  assign busy     = (state != S_IDLE);

  // Stage: receive FSM; samples every bit at mid-period
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 18'd0;
      idx       <= 3'd0;
      baud_lat  <= 1'b0;
      rx_vld_p0 <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_vld_p0 <= 1'b0;
      if (capture_clear)
        frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            baud_lat <= baud_rate;
            cnt      <= (bit_period(baud_rate) >> 1) - 18'd1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (cnt_zero) begin
            if (!rx_bit) begin
              cnt   <= bit_period(baud_lat) - 18'd1;
              idx   <= 3'd0;
              state <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 18'd1;
          end
        end
        S_DATA: begin
          if (cnt_zero) begin
            cnt <= bit_period(baud_lat) - 18'd1;
            idx <= idx + 3'd1;
            if (idx == 3'd7)
              state <= S_STOP;
          end else begin
            cnt <= cnt - 18'd1;
          end
        end
        S_STOP: begin
          if (cnt_zero) begin
            state <= S_IDLE;
            if (rx_bit)
              rx_vld_p0 <= 1'b1;
            else if (!capture_clear)
              frame_err <= 1'b1;
          end else begin
            cnt <= cnt - 18'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if ((state == S_DATA) && cnt_zero)
      shreg[idx] <= rx_bit;
  end

  // Stage: delivery into the buffer; a clear in the same cycle drops the byte
  assign store_ok = rx_vld_p0 && capture_en && !ioctl_upload && !capture_clear && keep_byte(shreg);
  assign wr_en    = store_ok && (capture_len != FULL);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      capture_len <= '0;
      overflow    <= 1'b0;
    end else if (capture_clear) begin
      capture_len <= '0;
      overflow    <= 1'b0;
    end else if (store_ok) begin
      if (capture_len == FULL)
        overflow <= 1'b1;
      else
        capture_len <= capture_len + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en)
      mem[capture_len[ADDR_W-1:0]] <= shreg;
  end

  // Stage: upload read, RAM register then output register
  assign in_range = (32'(ioctl_addr) < 32'(capture_len));

  always_ff @(posedge clk_sys) begin
    if (ioctl_rd)
      ram_q_p0 <= mem[ioctl_addr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_vld_p0 <= 1'b0;
      rd_ok_p0  <= 1'b0;
      ioctl_din <= 8'h00;
    end else begin
      rd_vld_p0 <= ioctl_rd;
      if (ioctl_rd)
        rd_ok_p0 <= in_range;
      if (rd_vld_p0)
        ioctl_din <= rd_ok_p0 ? ram_q_p0 : 8'h00;
    end
  end

endmodule

// File: doc/uart_save_capture.md
Name: uart_save_capture

Overview:
- Captures the machine's serial output (6850 ACIA TXD, e.g. BASIC SAVE/LIST) into an on-chip byte buffer.
- Serves the buffer to the HPS via the ioctl upload path, so saved programs become files.
- This is the reverse of the Load Ascii download path.
- Sits in emu beside uk101: taps the uk101 txd output and the hps_io ioctl upload signals, all on clk_sys.

Parameters:
- CLK_HZ, 48000000, clk_sys frequency in Hz; sets the baud divisors.
- ADDR_W, 15, log2 of buffer depth in bytes (default 32768).

Ports:
- clk_sys  in  1  system clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- capture_en  in  1  arms capture; the receiver only stores bytes while high.
- capture_clear  in  1  single-cycle pulse; empties the buffer and clears flags.
- baud_rate  in  1  0 = 9600 baud, 1 = 300 baud; sampled only in IDLE.
- txd  in  1  serial line from the machine; idle high, 8N1, asynchronous to clk_sys.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_rd  in  1  single-cycle read strobe from HPS.
- ioctl_addr  in  16  upload byte address.
- ioctl_din  out  8  read data returned to HPS.
- capture_len  out  ADDR_W+1  number of bytes currently stored.
- overflow  out  1  sticky; a byte was dropped because the buffer was full.
- frame_err  out  1  sticky; a stop bit was sampled low.
- busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset values: ioctl_din=0x00, capture_len=0, overflow=0, frame_err=0, busy=0, RX FSM=IDLE, txd synchroniser preset to 1.
- txd passes through a 2-flop synchroniser; all further references are to the synchronised signal.
- Bit period BP = CLK_HZ/9600 (5000) or CLK_HZ/300 (160000). The counter is 18 bits wide.
- baud_rate is latched on the IDLE->START transition and held for the whole frame.
- FSM states:
  - IDLE: on a falling edge of txd, go to START and load counter = BP/2-1.
  - START: at count 0, if txd=0 go to DATA with counter = BP-1 and bit index 0; if txd=1 (glitch) return to IDLE with no flag.
  - DATA: at each count 0, shift txd into bit[index] (LSB first) and reload BP-1. After bit 7 go to STOP.
  - STOP: at count 0, if txd=1 deliver the byte; if txd=0 set frame_err and discard the byte. Return to IDLE in both cases.
- Delivery:
  - If capture_en=1 and ioctl_upload=0 and capture_len < 2^ADDR_W: write the byte to buffer[capture_len] and increment capture_len in the same cycle.
  - If the buffer is full: set overflow and drop the byte; capture_len holds at 2^ADDR_W.
  - If capture_en=0 or ioctl_upload=1: drop the byte silently.
- The receiver keeps framing bytes regardless of capture_en, so it never desynchronises mid-stream.
- capture_clear: next cycle capture_len=0, overflow=0, frame_err=0; buffer contents are not erased.
  - If capture_clear coincides with a delivery, clear wins and the byte is dropped.
  - A frame already in progress completes normally.
- Upload read port:
  - Buffer is a single-clock, dual-port block RAM: write port from the RX, read port from ioctl.
  - On ioctl_rd, ioctl_din is valid on the 2nd rising edge after the strobe (one RAM register plus one output register) and holds until the next read.
  - If ioctl_addr >= capture_len, return 0x00.
  - Address bits above ADDR_W-1 make the address out of range, so 0x00 is returned.
- Reset mid-frame returns the FSM to IDLE immediately and discards the partial byte.

Optional Feature:
- Macro: UK101_SAVE_FILTER_EN.
- When defined: delivered bytes 0x00 (NUL padding) and 0x7F (rubout) are discarded before storage. They do not advance capture_len and never set overflow. 0x0A and 0x0D are always stored.
- When undefined: every correctly framed byte is stored unchanged.

Test Plan:
- 9600 baud, capture_en=1, send 0x41 0x0D 0x0A -> capture_len=3. Uploads from addr 0,1,2 return 0x41, 0x0D, 0x0A; addr 3 returns 0x00.
- baud_rate=1 (300 baud), send 0x55 -> byte stored after about 9.5*160000 cycles. A 2500-cycle low glitch on idle txd leaves capture_len unchanged and frame_err=0.
- Send 0x33 with stop bit forced low -> frame_err=1 and capture_len unchanged. Then send 0x34 -> stored at addr 0.
- ADDR_W=4: send 17 bytes -> capture_len=16 and overflow=1. Pulse capture_clear -> capture_len=0 and overflow=0.
- capture_clear on the same cycle as a delivery -> capture_len=0. Holding ioctl_upload=1 while a byte arrives -> byte dropped.
- With UK101_SAVE_FILTER_EN, send 0x00 0x42 0x7F -> capture_len=1 and addr 0 returns 0x42. Without the macro -> capture_len=3.
